// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: scan index and frame data in,
// active-low anode/segment/decimal-point drive and frame pulse out.
interface seg7_scan_driver_if;
   logic [2:0]  scan_idx;
   logic [31:0] value;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic        lz_blank;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;

   modport master (
      output scan_idx, value, dp_in, digit_en, lz_blank,
      input  an, seg, dp, frame_start
   );

   modport slave (
      input  scan_idx, value, dp_in, digit_en, lz_blank,
      output an, seg, dp, frame_start
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode seven-segment back end: per-frame value snapshot,
// anti-ghosting blank interval on every index change, registered active-low drive.
module seg7_scan_driver #(
   parameter int BLANK_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  cur_q, cur_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] snap_q, snap_d;
   logic [7:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic        frame_start_q, frame_start_d;

   logic        change_s;
   logic [3:0]  nib_s;
   logic        lzb_s;
   logic        lit_s;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign change_s = (bus.scan_idx != idx_q);

   // Next-state: any index change (or leaving IDLE) restarts the blank interval.
   always_comb begin
      state_d       = state_q;
      idx_d         = bus.scan_idx;
      cur_d         = cur_q;
      cnt_d         = cnt_q;
      snap_d        = snap_q;
      frame_start_d = 1'b0;
      if ((state_q == ST_IDLE) || change_s) begin
         state_d = ST_BLANK;
         cur_d   = bus.scan_idx;
         cnt_d   = 8'(BLANK_CYCLES - 1);
         if (bus.scan_idx == 3'd0) begin
            snap_d        = bus.value;
            frame_start_d = 1'b1;
         end else begin
            snap_d        = snap_q;
         end
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (cnt_q == 8'd0) begin
                  state_d = ST_SHOW;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            ST_SHOW:  state_d = ST_SHOW;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Output drive is computed from next-state so the registered pins track the FSM edge-for-edge.
   always_comb begin
      nib_s = snap_d[{cur_d, 2'b00} +: 4];
      lzb_s = bus.lz_blank && (cur_d != 3'd0) && ((snap_d >> {cur_d, 2'b00}) == 32'h0);
      lit_s = (state_d == ST_SHOW) && bus.digit_en[cur_d] && !lzb_s;
      if (lit_s) begin
         an_d  = ~(8'h01 << cur_d);
         seg_d = hex_seg(nib_s);
         dp_d  = ~bus.dp_in[cur_d];
      end else begin
         an_d  = 8'hFF;
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= 3'd0;
         cur_q         <= 3'd0;
         cnt_q         <= 8'd0;
         snap_q        <= 32'h0;
         an_q          <= 8'hFF;
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cur_q         <= cur_d;
         cnt_q         <= cnt_d;
         snap_q        <= snap_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with hand-computed expected drive values.
module tb_seg7_scan_driver;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   seg7_scan_driver_if sif();

   seg7_scan_driver #(.BLANK_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Move to a new index, confirm blanking, then confirm the lit (or dark) digit.
   task automatic show_digit(input logic [2:0] idx, input logic [7:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp, input string tag);
      sif.scan_idx = idx;
      tick(1);
      check({tag, "_blank0"}, {24'h0, sif.an}, 32'hFF);
      check({tag, "_fs"}, {31'h0, sif.frame_start}, {31'h0, (idx == 3'd0)});
      tick(3);
      check({tag, "_blank3"}, {24'h0, sif.an}, 32'hFF);
      tick(1);
      check({tag, "_an"}, {24'h0, sif.an}, {24'h0, e_an});
      check({tag, "_seg"}, {25'h0, sif.seg}, {25'h0, e_seg});
      check({tag, "_dp"}, {31'h0, sif.dp}, {31'h0, e_dp});
      tick(2);
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      rst          = 1'b0;
      sif.scan_idx = 3'd0;
      sif.value    = 32'h89AB_CDEF;
      sif.dp_in    = 8'h00;
      sif.digit_en = 8'hFF;
      sif.lz_blank = 1'b0;

      // Reset hold and release
      tick(3);
      check("rst_an", {24'h0, sif.an}, 32'hFF);
      check("rst_seg", {25'h0, sif.seg}, 32'h7F);
      check("rst_dp", {31'h0, sif.dp}, 32'h1);
      check("rst_fs", {31'h0, sif.frame_start}, 32'h0);
      rst = 1'b1;
      tick(1);
      check("rel_an", {24'h0, sif.an}, 32'hFF);
      check("rel_fs", {31'h0, sif.frame_start}, 32'h1);
      tick(1);
      check("rel_fs_drop", {31'h0, sif.frame_start}, 32'h0);
      tick(2);
      check("rel_blank", {24'h0, sif.an}, 32'hFF);
      tick(1);
      check("rel_an_d0", {24'h0, sif.an}, 32'hFE);
      check("rel_seg_d0", {25'h0, sif.seg}, 32'h0E);
      tick(2);

      // Full frame of 89ABCDEF
      show_digit(3'd1, 8'hFD, 7'h06, 1'b1, "ff1");
      show_digit(3'd2, 8'hFB, 7'h21, 1'b1, "ff2");
      show_digit(3'd3, 8'hF7, 7'h46, 1'b1, "ff3");
      show_digit(3'd4, 8'hEF, 7'h03, 1'b1, "ff4");
      show_digit(3'd5, 8'hDF, 7'h08, 1'b1, "ff5");
      show_digit(3'd6, 8'hBF, 7'h10, 1'b1, "ff6");
      show_digit(3'd7, 8'h7F, 7'h00, 1'b1, "ff7");
      show_digit(3'd0, 8'hFE, 7'h0E, 1'b1, "ff0");

      // Snapshot isolation
      sif.value = 32'h1234_5678;
      show_digit(3'd1, 8'hFD, 7'h06, 1'b1, "sn_old1");
      show_digit(3'd0, 8'hFE, 7'h00, 1'b1, "sn0");
      sif.value = 32'h0;
      show_digit(3'd1, 8'hFD, 7'h78, 1'b1, "sn1");
      show_digit(3'd4, 8'hEF, 7'h19, 1'b1, "sn4");
      show_digit(3'd0, 8'hFE, 7'h40, 1'b1, "sn_new0");
      show_digit(3'd1, 8'hFD, 7'h40, 1'b1, "sn_new1");

      // Leading-zero suppression
      sif.lz_blank = 1'b1;
      sif.value    = 32'h0000_0120;
      show_digit(3'd0, 8'hFE, 7'h40, 1'b1, "lz0");
      show_digit(3'd1, 8'hFD, 7'h24, 1'b1, "lz1");
      show_digit(3'd2, 8'hFB, 7'h79, 1'b1, "lz2");
      show_digit(3'd3, 8'hFF, 7'h7F, 1'b1, "lz3");
      show_digit(3'd7, 8'hFF, 7'h7F, 1'b1, "lz7");
      sif.value = 32'h0;
      show_digit(3'd0, 8'hFE, 7'h40, 1'b1, "lzz0");
      show_digit(3'd1, 8'hFF, 7'h7F, 1'b1, "lzz1");
      show_digit(3'd5, 8'hFF, 7'h7F, 1'b1, "lzz5");

      // Digit enables and decimal points
      sif.lz_blank = 1'b0;
      sif.value    = 32'h89AB_CDEF;
      sif.digit_en = 8'h0F;
      sif.dp_in    = 8'h04;
      show_digit(3'd0, 8'hFE, 7'h0E, 1'b1, "en0");
      show_digit(3'd2, 8'hFB, 7'h21, 1'b0, "en2");
      show_digit(3'd4, 8'hFF, 7'h7F, 1'b1, "en4");
      show_digit(3'd7, 8'hFF, 7'h7F, 1'b1, "en7");
      show_digit(3'd3, 8'hF7, 7'h46, 1'b1, "en3");

      // Short dwell keeps everything dark
      for (int i = 0; i < 6; i++) begin
         sif.scan_idx = 3'(i + 4);
         tick(1);
         check("glitch_a", {24'h0, sif.an}, 32'hFF);
         tick(1);
         check("glitch_b", {24'h0, sif.an}, 32'hFF);
      end
      sif.scan_idx = 3'd3;
      tick(4);
      check("dwell4_dark", {24'h0, sif.an}, 32'hFF);
      sif.scan_idx = 3'd2;
      tick(5);
      check("settle_an", {24'h0, sif.an}, 32'hFB);

      // Asynchronous reset while a digit is lit
      #2;
      rst = 1'b0;
      #1;
      check("arst_an", {24'h0, sif.an}, 32'hFF);
      check("arst_seg", {25'h0, sif.seg}, 32'h7F);
      check("arst_dp", {31'h0, sif.dp}, 32'h1);
      check("arst_fs", {31'h0, sif.frame_start}, 32'h0);
      tick(1);
      rst = 1'b1;
      tick(5);
      check("post_rst_an", {24'h0, sif.an}, 32'hFB);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Display back-end stage that consumes the 3-bit scan index produced by the display's gate-level scan counter and drives an 8-digit common-anode seven-segment display. It snapshots a 32-bit hex value once per frame, inserts a programmable anti-ghosting blank interval on every digit change, applies per-digit enables and leading-zero suppression, and produces registered active-low anode, segment and decimal-point outputs.

## Interface
- BLANK_CYCLES, 4: dead-time clocks with all anodes off after each index change; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- scan_idx  in  3  current digit index from the scan counter; synchronous to clk.
- value  in  32  hex value; nibble i (bits 4i+3:4i) is shown on digit i.
- dp_in  in  8  decimal point request per digit, 1 = lit.
- digit_en  in  8  per-digit enable, 1 = digit may light.
- lz_blank  in  1  1 = suppress leading zeros.
- an  out  8  anode drive, active-low, bit i = digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Reset (rst=0, asynchronous): state IDLE, idx_q=0, cur=0, cnt=0, snap=0; an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
- idx_q registers scan_idx every cycle; change = (scan_idx != idx_q).
- States: IDLE, BLANK, SHOW.
  - IDLE: first edge after reset release -> BLANK (treated as a change).
  - Any state, change (or IDLE exit): cur <= scan_idx; cnt <= BLANK_CYCLES-1; -> BLANK. If scan_idx==0: snap <= value, frame_start <= 1 for that cycle only.
  - BLANK, no change: cnt==0 -> SHOW, else cnt decrements.
  - SHOW: hold until change.
- Outputs in IDLE/BLANK: an=FF, seg=7F, dp=1.
- Outputs in SHOW: nibble n = snap[4cur+3:4cur]; lit = digit_en[cur] and not lzb(cur); an = lit ? ~(1<<cur) : FF; seg = lit ? hex(n) : 7F; dp = lit ? ~dp_in[cur] : 1.
- lzb(i) = lz_blank and i!=0 and snap nibbles 7..i all zero. Digit 0 is never zero-suppressed.
- hex(): standard full 0-F table, active-low; e.g. 0->40, 1->79, 2->24, 8->00, A->08, b->03, F->0E.
- value, dp_in, digit_en, lz_blank sampled live except value, which is used only through snap (no intra-frame tearing).
- Out-of-order or repeated-skip indices are legal: every change restarts BLANK; no monotonic-order check.

## Timing
- All outputs registered; no combinational path input->output.
- scan_idx change presented before edge E: idx_q updates at E, state enters BLANK at E+1 (compare uses idx_q of E-1... i.e. detected at edge E, BLANK outputs visible after E).
- Precisely: change visible on scan_idx in cycle t -> outputs blank from edge ending cycle t; digit lit after BLANK_CYCLES further edges.
- frame_start asserted in the same cycle BLANK is entered for index 0.
- Change arriving during BLANK: counter reloads, cur updates, blanking extends; no lit output for abandoned index.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous), not at next edge.
- Index must stay stable ≥ BLANK_CYCLES+1 clocks for its digit to light; shorter dwell -> digit stays dark (legal).

## Test plan
- Reset: hold rst=0 with arbitrary inputs -> an=FF, seg=7F, dp=1, frame_start=0; release -> BLANK for 4 clocks, then digit 0 lit with an=FE.
- Full frame: value=32'h89AB_CDEF, digit_en=FF, lz_blank=0, scan_idx stepping 0..7 every 16 clocks -> digit 0 seg=0E, digit 3 seg=46 (C), an walks FE,FD,…,7F; frame_start one pulse per wrap to 0.
- Snapshot: change value mid-frame from 12345678 to 0 -> remaining digits still show 1234xxxx nibbles; new value appears only after next index 0.
- Leading zero: value=0000_0120, lz_blank=1 -> digits 7..3 an=FF, digits 2,1,0 show 1,2,0; value=0 -> only digit 0 lit showing 0 (seg=40).
- Enables and dp: digit_en=8'h0F, dp_in=8'h04 -> digits 4..7 dark; digit 2 dp=0, others dp=1.
- Glitch/short dwell: scan_idx changes every 2 clocks with BLANK_CYCLES=4 -> an stays FF throughout; mid-sequence rst pulse -> outputs reset asynchronously within same cycle.
